// File: rtl/midi_voice_period_bank_pkg.sv
// Shared note table, FSM states and constants for the MIDI voice period bank.
// Half-periods are in sample ticks for the lowest octave (notes 0-11).
package midi_voice_period_bank_pkg;

    localparam int NOTES_PER_OCT = 12;
    localparam int BASE_W = 15;

    localparam logic [BASE_W-1:0] BASE [NOTES_PER_OCT] = '{
        15'd23889, 15'd22548, 15'd21282, 15'd20088,
        15'd18960, 15'd17896, 15'd16892, 15'd15944,
        15'd15049, 15'd14204, 15'd13407, 15'd12654
    };

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        WRITE
    } conv_state_t;

endpackage

// File: rtl/midi_voice_osc.sv
// One voice: holds its half-period and runs a square-wave phase counter.
// A write from the converter always takes priority over a sample tick.
module midi_voice_osc
    import midi_voice_period_bank_pkg::*;
#(
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              wr_en,
    input  logic              wr_gate,
    input  logic [TICK_W-1:0] wr_period,
    output logic              active,
    output logic              square,
    output logic [TICK_W-1:0] period
);

    localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            square <= 1'b0;
            period <= '0;
            cnt    <= '0;
        end else if (wr_en) begin
            active <= wr_gate;
            square <= 1'b0;
            cnt    <= '0;
            if (wr_gate) begin
                period <= wr_period;
            end
        end else if (sample_tick && active) begin
            if (cnt == period - ONE) begin
                cnt    <= '0;
                square <= ~square;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/midi_voice_period_bank.sv
// Multi-voice MIDI note to half-period converter with per-voice square oscillators.
// The octave is found by repeated subtraction, one octave per cycle.
module midi_voice_period_bank
    import midi_voice_period_bank_pkg::*;
#(
    parameter  int VOICES = 4,
    parameter  int TICK_W = 24,
    localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [VW-1:0]            cmd_voice,
    input  logic [6:0]               cmd_note,
    input  logic                     cmd_gate,
    output logic [VOICES-1:0]        voice_active,
    output logic [VOICES-1:0]        voice_square,
    output logic [VOICES*TICK_W-1:0] voice_period
);

    localparam logic [6:0] NPO = 7'(NOTES_PER_OCT);

    conv_state_t       state, state_d;
    logic [6:0]        rem;
    logic [3:0]        oct;
    logic [VW-1:0]     voice;
    logic              gate;
    logic [TICK_W-1:0] new_period;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rem < NPO) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            oct   <= '0;
            voice <= '0;
            gate  <= 1'b0;
        end else if (state == IDLE && cmd_valid) begin
            rem   <= cmd_note;
            oct   <= '0;
            voice <= cmd_voice;
            gate  <= cmd_gate;
        end else if (state == DIV && rem >= NPO) begin
            rem <= rem - NPO;
            oct <= oct + 4'd1;
        end
    end

    // rem is below 12 once WRITE is reached, so the low nibble indexes the table
    assign new_period = TICK_W'(BASE[rem[3:0]]) >> oct;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic wr_en;

        assign wr_en = (state == WRITE) && (voice == VW'(v));

        midi_voice_osc #(
            .TICK_W(TICK_W)
        ) u_osc (
            .clk        (clk),
            .reset      (reset),
            .sample_tick(sample_tick),
            .wr_en      (wr_en),
            .wr_gate    (gate),
            .wr_period  (new_period),
            .active     (voice_active[v]),
            .square     (voice_square[v]),
            .period     (voice_period[v*TICK_W +: TICK_W])
        );
    end

endmodule

// File: tb/tb_midi_voice_period_bank.sv
// Testbench for midi_voice_period_bank: directed scenarios plus randomized traffic
// against a tick-count reference model.
module tb_midi_voice_period_bank;

    localparam int V  = 5;
    localparam int TW = 24;
    localparam int VW = 3;
    localparam int BASE_T [12] = '{23889, 22548, 21282, 20088, 18960, 17896,
                                   16892, 15944, 15049, 14204, 13407, 12654};

    logic            clk = 1'b0;
    logic            reset;
    logic            sample_tick;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [VW-1:0]   cmd_voice;
    logic [6:0]      cmd_note;
    logic            cmd_gate;
    logic [V-1:0]    voice_active;
    logic [V-1:0]    voice_square;
    logic [V*TW-1:0] voice_period;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // model: per-voice state expressed as ticks elapsed since the last trigger
    bit m_active [V];
    int m_period [V];
    int m_ticks  [V];
    bit pend;
    int pend_due, pend_voice, pend_note;
    bit pend_gate;

    always #5 clk = ~clk;

    midi_voice_period_bank #(
        .VOICES(V),
        .TICK_W(TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_voice   (cmd_voice),
        .cmd_note    (cmd_note),
        .cmd_gate    (cmd_gate),
        .voice_active(voice_active),
        .voice_square(voice_square),
        .voice_period(voice_period)
    );

    function automatic int note_period(int n);
        return BASE_T[n % 12] >> (n / 12);
    endfunction

    function automatic int note_latency(int n);
        return n / 12 + 2;
    endfunction

    function automatic bit exp_square(int v);
        if (!m_active[v]) return 1'b0;
        return ((m_ticks[v] / m_period[v]) % 2) == 1;
    endfunction

    function automatic int dut_period(int v);
        return int'(voice_period[v*TW +: TW]);
    endfunction

    task automatic step();
        bit acc;
        bit wrote [V];
        acc = cmd_valid && !pend;
        @(posedge clk);
        cyc++;
        foreach (wrote[v]) wrote[v] = 1'b0;
        if (pend && cyc == pend_due) begin
            if (pend_voice < V) begin
                wrote[pend_voice]    = 1'b1;
                m_ticks[pend_voice]  = 0;
                m_active[pend_voice] = pend_gate;
                if (pend_gate) m_period[pend_voice] = note_period(pend_note);
            end
            pend = 1'b0;
        end
        for (int v = 0; v < V; v++)
            if (!wrote[v] && sample_tick && m_active[v]) m_ticks[v]++;
        if (acc) begin
            pend       = 1'b1;
            pend_due   = cyc + note_latency(int'(cmd_note));
            pend_voice = int'(cmd_voice);
            pend_note  = int'(cmd_note);
            pend_gate  = cmd_gate;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        sample_tick = 1'b0;
        pend        = 1'b0;
        for (int v = 0; v < V; v++) begin
            m_active[v] = 1'b0;
            m_period[v] = 0;
            m_ticks[v]  = 0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        vectors++;
        if (voice_active !== '0) begin
            errors++; $display("FAIL reset_active: got %b want 0", voice_active);
        end
        vectors++;
        if (voice_square !== '0) begin
            errors++; $display("FAIL reset_square: got %b want 0", voice_square);
        end
        vectors++;
        if (voice_period !== '0) begin
            errors++; $display("FAIL reset_period: got %h want 0", voice_period);
        end
    endtask

    task automatic test_latency(input int v, input int n, input int exp_per,
                                input int exp_lat);
        int lat;
        bit early;
        cmd_voice = VW'(v);
        cmd_note  = 7'(n);
        cmd_gate  = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat   = 0;
        early = 1'b0;
        while (cmd_ready !== 1'b1 && lat < 40) begin
            if (voice_active[v] !== 1'b0 || dut_period(v) != 0) early = 1'b1;
            step();
            lat++;
        end
        vectors++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL latency_n%0d: got %0d want %0d", n, lat, exp_lat);
        end
        vectors++;
        if (early) begin
            errors++; $display("FAIL early_update_n%0d: got 1 want 0", n);
        end
        vectors++;
        if (dut_period(v) != exp_per || dut_period(v) != m_period[v]) begin
            errors++;
            $display("FAIL period_n%0d: got %0d want %0d", n, dut_period(v), exp_per);
        end
        vectors++;
        if (voice_active[v] !== 1'b1) begin
            errors++; $display("FAIL active_n%0d: got %b want 1", n, voice_active[v]);
        end
    endtask

    task automatic test_square();
        int  last, toggles;
        logic prev;
        sample_tick = 1'b1;
        last    = -1;
        toggles = 0;
        prev    = voice_square[3];
        for (int i = 1; i <= 130; i++) begin
            step();
            vectors++;
            if (voice_square[3] !== exp_square(3)) begin
                errors++;
                $display("FAIL square_c%0d: got %b want %b", i, voice_square[3], exp_square(3));
            end
            if (voice_square[3] !== prev) begin
                if (last >= 0) begin
                    vectors++;
                    if (i - last != 15) begin
                        errors++; $display("FAIL toggle_gap: got %0d want 15", i - last);
                    end
                end
                last = i;
                toggles++;
            end
            prev = voice_square[3];
        end
        vectors++;
        if (toggles < 8) begin
            errors++; $display("FAIL toggle_count: got %0d want 8", toggles);
        end
        sample_tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit got;
        int n;
        cmd_voice = VW'(4);
        cmd_note  = 7'd100;
        cmd_gate  = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_voice = VW'(0);
        cmd_note  = 7'd30;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            vectors++;
            if (cmd_ready !== !pend) begin
                errors++; $display("FAIL bp_ready_c%0d: got %b want %b", i, cmd_ready, !pend);
            end
            if (!pend) got = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (!got || n != note_latency(30)) begin
            errors++; $display("FAIL bp_second_latency: got %0d want %0d", n, note_latency(30));
        end
        vectors++;
        if (dut_period(4) != 74 || dut_period(4) != m_period[4]) begin
            errors++; $display("FAIL bp_first_period: got %0d want 74", dut_period(4));
        end
        vectors++;
        if (dut_period(0) != 4223 || dut_period(0) != m_period[0]) begin
            errors++; $display("FAIL bp_second_period: got %0d want 4223", dut_period(0));
        end
        vectors++;
        if (voice_active[4] !== 1'b1 || voice_active[0] !== 1'b1) begin
            errors++; $display("FAIL bp_active: got %b want 1_0001", voice_active);
        end
    endtask

    task automatic test_retrigger();
        int n;
        sample_tick = 1'b1;
        for (int i = 0; i < 900; i++) begin
            step();
            vectors++;
            if (voice_square[2] !== exp_square(2)) begin
                errors++;
                $display("FAIL pre_retrig_sq_c%0d: got %b want %b", i, voice_square[2], exp_square(2));
            end
        end
        cmd_voice = VW'(2);
        cmd_note  = 7'd72;
        cmd_gate  = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (dut_period(2) != 373 || voice_square[2] !== 1'b0) begin
            errors++;
            $display("FAIL retrig_state: got %0d/%b want 373/0", dut_period(2), voice_square[2]);
        end
        for (int i = 1; i <= 380; i++) begin
            step();
            vectors++;
            if (voice_square[2] !== exp_square(2)) begin
                errors++;
                $display("FAIL retrig_sq_t%0d: got %b want %b", i, voice_square[2], exp_square(2));
            end
        end
        cmd_gate  = 1'b0;
        cmd_note  = 7'($urandom_range(0, 127));
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        sample_tick = 1'b0;
        vectors++;
        if (voice_active[2] !== 1'b0 || voice_square[2] !== 1'b0) begin
            errors++;
            $display("FAIL note_off: got %b/%b want 0/0", voice_active[2], voice_square[2]);
        end
        vectors++;
        if (dut_period(2) != 373) begin
            errors++; $display("FAIL off_period_kept: got %0d want 373", dut_period(2));
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 400; i++) begin
            sample_tick = 1'($urandom_range(0, 1));
            if (!cmd_valid && $urandom_range(0, 3) == 0) begin
                cmd_voice = VW'($urandom_range(0, 7));
                cmd_note  = 7'($urandom_range(0, 127));
                cmd_gate  = ($urandom_range(0, 3) != 0);
                cmd_valid = 1'b1;
            end
            acc = cmd_valid && !pend;
            step();
            if (acc) cmd_valid = 1'b0;
            vectors++;
            if (cmd_ready !== !pend) begin
                errors++; $display("FAIL rnd_ready_c%0d: got %b want %b", i, cmd_ready, !pend);
            end
            for (int v = 0; v < V; v++) begin
                vectors++;
                if (voice_active[v] !== m_active[v] || voice_square[v] !== exp_square(v) ||
                    dut_period(v) != m_period[v]) begin
                    errors++;
                    $display("FAIL rnd_v%0d_c%0d: got %b/%b/%0d want %b/%b/%0d", v, i,
                             voice_active[v], voice_square[v], dut_period(v),
                             m_active[v], exp_square(v), m_period[v]);
                end
            end
        end
        cmd_valid   = 1'b0;
        sample_tick = 1'b0;
        for (int i = 0; i < 40 && pend; i++) step();
    endtask

    task automatic test_bad_voice(input int bv);
        int n;
        cmd_voice = VW'(bv);
        cmd_note  = 7'd50;
        cmd_gate  = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (n != 6) begin
            errors++; $display("FAIL bad_voice%0d_latency: got %0d want 6", bv, n);
        end
        for (int v = 0; v < V; v++) begin
            vectors++;
            if (voice_active[v] !== m_active[v] || voice_square[v] !== exp_square(v) ||
                dut_period(v) != m_period[v]) begin
                errors++;
                $display("FAIL bad_voice%0d_v%0d: got %b/%0d want %b/%0d", bv, v,
                         voice_active[v], dut_period(v), m_active[v], m_period[v]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cmd_voice = VW'(3);
        cmd_note  = 7'd100;
        cmd_gate  = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        vectors++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL mid_busy: got %b want 0", cmd_ready);
        end
        do_reset();
        repeat (12) step();
        vectors++;
        if (voice_active !== '0 || voice_period !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_abort: got %b/%h/%b want 0/0/1",
                     voice_active, voice_period, cmd_ready);
        end
        test_latency(3, 0, 23889, 2);
    endtask

    initial begin
        reset       = 1'b1;
        sample_tick = 1'b0;
        cmd_valid   = 1'b0;
        cmd_voice   = '0;
        cmd_note    = '0;
        cmd_gate    = 1'b0;
        test_reset();
        test_latency(0, 0, 23889, 2);
        test_latency(1, 69, 443, 7);
        test_latency(2, 60, 746, 7);
        test_latency(3, 127, 15, 12);
        test_square();
        test_back_to_back();
        test_retrigger();
        test_random();
        test_bad_voice(5);
        test_bad_voice(7);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
